// File: rtl/draw_engine.sv
// draw_engine: turns one plot / fill-rect / clear command into a row-major
// stream of framebuffer pixel writes, one per cycle when the framebuffer is ready.
module draw_engine #(
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120
) (
  input  logic       pixel_clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_x0,
  input  logic [7:0] cmd_y0,
  input  logic [7:0] cmd_x1,
  input  logic [7:0] cmd_y1,
  input  logic [2:0] cmd_color,
  input  logic       wr_ready,
  output logic       wr_en,
  output logic [7:0] wr_x,
  output logic [7:0] wr_y,
  output logic [2:0] wr_color,
  output logic       busy
);

  localparam logic [7:0] X_LAST = 8'(FB_WIDTH - 1);
  localparam logic [7:0] Y_LAST = 8'(FB_HEIGHT - 1);

  localparam logic [1:0] OP_PLOT  = 2'b00;
  localparam logic [1:0] OP_RECT  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  typedef enum logic {IDLE, DRAW} state_t;

  state_t     state_reg, state_next;
  logic [7:0] x_reg, x_next;
  logic [7:0] y_reg, y_next;
  logic [7:0] xmin_reg, xmin_next;
  logic [7:0] xmax_reg, xmax_next;
  logic [7:0] ymax_reg, ymax_next;
  logic [2:0] color_reg, color_next;

  // Normalised bounds of the command currently on the input port
  logic [7:0] lo_x, hi_x, lo_y, hi_y;
  logic [7:0] hi_x_clamped, hi_y_clamped;
  logic       cmd_empty;

  // Normalise the presented command: order corners, clamp maxima, flag empty work
  always_comb begin
    lo_x      = cmd_x0;
    hi_x      = cmd_x0;
    lo_y      = cmd_y0;
    hi_y      = cmd_y0;
    cmd_empty = 1'b0;
    case (cmd_op)
      OP_PLOT: begin
        lo_x = cmd_x0;
        hi_x = cmd_x0;
        lo_y = cmd_y0;
        hi_y = cmd_y0;
      end
      OP_RECT: begin
        lo_x = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
        hi_x = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
        lo_y = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
        hi_y = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
      end
      OP_CLEAR: begin
        lo_x = 8'd0;
        hi_x = X_LAST;
        lo_y = 8'd0;
        hi_y = Y_LAST;
      end
      default: cmd_empty = 1'b1;  // no-op
    endcase
    hi_x_clamped = (hi_x > X_LAST) ? X_LAST : hi_x;
    hi_y_clamped = (hi_y > Y_LAST) ? Y_LAST : hi_y;
    // A minimum corner off-screen means nothing is left to draw
    if ((lo_x > X_LAST) || (lo_y > Y_LAST)) begin
      cmd_empty = 1'b1;
    end
  end

  // State and scan-counter registers
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state_reg <= IDLE;
      x_reg     <= 8'd0;
      y_reg     <= 8'd0;
      xmin_reg  <= 8'd0;
      xmax_reg  <= 8'd0;
      ymax_reg  <= 8'd0;
      color_reg <= 3'd0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      xmin_reg  <= xmin_next;
      xmax_reg  <= xmax_next;
      ymax_reg  <= ymax_next;
      color_reg <= color_next;
    end
  end

  // Accept commands in IDLE; advance the scan only when a write transfers
  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    xmin_next  = xmin_reg;
    xmax_next  = xmax_reg;
    ymax_next  = ymax_reg;
    color_next = color_reg;
    case (state_reg)
      IDLE: begin
        // Empty and no-op commands are consumed here without leaving IDLE
        if (cmd_valid && !cmd_empty) begin
          state_next = DRAW;
          x_next     = lo_x;
          y_next     = lo_y;
          xmin_next  = lo_x;
          xmax_next  = hi_x_clamped;
          ymax_next  = hi_y_clamped;
          color_next = cmd_color;
        end
      end
      DRAW: begin
        if (wr_ready) begin
          if (x_reg == xmax_reg) begin
            if (y_reg == ymax_reg) begin
              state_next = IDLE;
            end else begin
              x_next = xmin_reg;
              y_next = y_reg + 8'd1;
            end
          end else begin
            x_next = x_reg + 8'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Write port is driven straight from the scan registers so it holds while stalled
  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg == DRAW);
  assign wr_en     = (state_reg == DRAW);
  assign wr_x      = x_reg;
  assign wr_y      = y_reg;
  assign wr_color  = color_reg;

endmodule

// File: tb/tb_draw_engine.sv
// Bench for draw_engine: directed commands push expected pixels into a queue,
// an independent monitor pops and compares every transferred write.
module tb_draw_engine;

  logic       pixel_clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [2:0] cmd_color;
  logic       wr_ready;
  logic       wr_en;
  logic [7:0] wr_x, wr_y;
  logic [2:0] wr_color;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int xfer_count  = 0;

  logic [18:0] exp_q[$];

  draw_engine #(.FB_WIDTH(160), .FB_HEIGHT(120)) dut (
    .pixel_clock(pixel_clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_x0     (cmd_x0),
    .cmd_y0     (cmd_y0),
    .cmd_x1     (cmd_x1),
    .cmd_y1     (cmd_y1),
    .cmd_color  (cmd_color),
    .wr_ready   (wr_ready),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_color   (wr_color),
    .busy       (busy)
  );

  initial pixel_clock = 1'b0;
  always #5 pixel_clock = ~pixel_clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [18:0] pix(input int x, input int y, input int c);
    return {8'(x), 8'(y), 3'(c)};
  endfunction

  // Monitor: every transfer seen mid-cycle must match the head of the queue
  initial begin
    forever begin
      @(negedge pixel_clock);
      if (wr_en && wr_ready) begin
        xfer_count++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got x=%0d y=%0d c=%0d expected none at %0t",
                   wr_x, wr_y, wr_color, $time);
        end else begin
          check("pixel", {13'd0, wr_x, wr_y, wr_color}, {13'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Watchdog so a stuck design still ends the run
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  // Present one command for exactly one accepting edge; returns at edge+1
  task automatic send(input logic [1:0] op, input int x0, input int y0,
                      input int x1, input int y1, input int c);
    check("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_op    = op;
    cmd_x0    = 8'(x0);
    cmd_y0    = 8'(y0);
    cmd_x1    = 8'(x1);
    cmd_y1    = 8'(y1);
    cmd_color = 3'(c);
    cmd_valid = 1'b1;
    @(posedge pixel_clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Count cycles with busy high, bounded by budget
  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (busy && cycles < budget) begin
      cycles++;
      @(posedge pixel_clock);
      #1;
    end
  endtask

  int cyc;
  int base;
  int n;

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b11;
    cmd_x0    = 8'd0;
    cmd_y0    = 8'd0;
    cmd_x1    = 8'd0;
    cmd_y1    = 8'd0;
    cmd_color = 3'd0;
    wr_ready  = 1'b1;
    repeat (2) @(posedge pixel_clock);
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_wr_en",     {31'd0, wr_en}, 32'd0);
    check("rst_wr_x",      {24'd0, wr_x}, 32'd0);
    check("rst_wr_y",      {24'd0, wr_y}, 32'd0);
    check("rst_wr_color",  {29'd0, wr_color}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(posedge pixel_clock);
    #1;

    // Plot (5,7) color 3: write one cycle after accept
    exp_q.push_back(pix(5, 7, 3));
    send(2'b00, 5, 7, 0, 0, 3);
    check("plot_latency_wr_en", {31'd0, wr_en}, 32'd1);
    @(posedge pixel_clock);
    #1;
    check("plot_done_wr_en", {31'd0, wr_en}, 32'd0);
    check("plot_done_ready", {31'd0, cmd_ready}, 32'd1);
    check("plot_q_empty", exp_q.size(), 32'd0);

    // Rect with swapped corners
    exp_q.push_back(pix(10, 20, 5));
    exp_q.push_back(pix(11, 20, 5));
    exp_q.push_back(pix(12, 20, 5));
    exp_q.push_back(pix(10, 21, 5));
    exp_q.push_back(pix(11, 21, 5));
    exp_q.push_back(pix(12, 21, 5));
    send(2'b01, 12, 21, 10, 20, 5);
    wait_idle(100, cyc);
    check("rect_busy_cycles", cyc, 32'd6);
    check("rect_q_empty", exp_q.size(), 32'd0);

    // Rect clipped at the bottom-right corner
    exp_q.push_back(pix(158, 118, 1));
    exp_q.push_back(pix(159, 118, 1));
    exp_q.push_back(pix(158, 119, 1));
    exp_q.push_back(pix(159, 119, 1));
    send(2'b01, 158, 118, 200, 200, 1);
    wait_idle(100, cyc);
    check("clip_busy_cycles", cyc, 32'd4);
    check("clip_q_empty", exp_q.size(), 32'd0);

    // Off-screen plot: no writes, ready never drops
    send(2'b00, 170, 5, 0, 0, 2);
    for (int i = 0; i < 3; i++) begin
      check("offscreen_ready", {31'd0, cmd_ready}, 32'd1);
      check("offscreen_wr_en", {31'd0, wr_en}, 32'd0);
      @(posedge pixel_clock);
      #1;
    end

    // No-op command
    send(2'b11, 3, 3, 4, 4, 7);
    check("noop_busy", {31'd0, busy}, 32'd0);
    @(posedge pixel_clock);
    #1;

    // Full clear
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 160; x++) begin
        exp_q.push_back(pix(x, y, 0));
      end
    end
    base = xfer_count;
    send(2'b10, 9, 9, 9, 9, 0);
    wait_idle(20000, cyc);
    check("clear_busy_cycles", cyc, 32'd19200);
    check("clear_xfers", xfer_count - base, 32'd19200);
    check("clear_q_empty", exp_q.size(), 32'd0);

    // Back-pressure on the first pixel of a 2-pixel rect
    exp_q.push_back(pix(0, 0, 4));
    exp_q.push_back(pix(1, 0, 4));
    base = xfer_count;
    wr_ready = 1'b0;
    send(2'b01, 0, 0, 1, 0, 4);
    for (int i = 0; i < 3; i++) begin
      check("stall_wr_en", {31'd0, wr_en}, 32'd1);
      check("stall_hold", {13'd0, wr_x, wr_y, wr_color}, {13'd0, pix(0, 0, 4)});
      @(posedge pixel_clock);
      #1;
    end
    wr_ready = 1'b1;
    check("stall_4th_hold", {13'd0, wr_x, wr_y, wr_color}, {13'd0, pix(0, 0, 4)});
    @(posedge pixel_clock);
    #1;
    check("stall_second", {13'd0, wr_x, wr_y, wr_color}, {13'd0, pix(1, 0, 4)});
    wait_idle(10, cyc);
    check("stall_xfers", xfer_count - base, 32'd2);
    check("stall_q_empty", exp_q.size(), 32'd0);

    // Reset while the 100th write of a clear is presented
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 160; x++) begin
        exp_q.push_back(pix(x, y, 2));
      end
    end
    base = xfer_count;
    send(2'b10, 0, 0, 0, 0, 2);
    n = 0;
    while ((xfer_count - base) < 99 && n < 500) begin
      n++;
      @(posedge pixel_clock);
      #1;
    end
    check("pre_reset_xfers", xfer_count - base, 32'd99);
    check("pre_reset_x", {24'd0, wr_x}, 32'd99);
    reset = 1'b1;
    @(posedge pixel_clock);
    #1;
    exp_q.delete();
    check("midrst_wr_en", {31'd0, wr_en}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    check("midrst_wr_x", {24'd0, wr_x}, 32'd0);
    reset = 1'b0;
    @(posedge pixel_clock);
    #1;
    check("post_rst_wr_en", {31'd0, wr_en}, 32'd0);

    // Plot (1,1) after the abandoned clear
    base = xfer_count;
    exp_q.push_back(pix(1, 1, 6));
    send(2'b00, 1, 1, 0, 0, 6);
    wait_idle(10, cyc);
    check("post_rst_plot_cycles", cyc, 32'd1);
    check("post_rst_plot_xfers", xfer_count - base, 32'd1);
    check("final_q_empty", exp_q.size(), 32'd0);
    repeat (2) @(posedge pixel_clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/draw_engine.md
Name: draw_engine

Overview:
- Hardware drawing engine between the CPU command registers and the framebuffer write port.
- Accepts one drawing command per handshake: plot, fill rectangle or clear screen.
- Emits one framebuffer pixel write per cycle (x, y, color, write strobe) in row-major order.
- Drives a busy flag that the status register reports to the CPU.

Parameters:
- FB_WIDTH, 160, framebuffer width in pixels; valid x is 0..FB_WIDTH-1
- FB_HEIGHT, 120, framebuffer height in pixels; valid y is 0..FB_HEIGHT-1

Ports:
- pixel_clock  input  1  single clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  engine can accept a command
- cmd_op  input  2  00 plot, 01 fill rect, 10 clear screen, 11 no-op
- cmd_x0  input  8  first corner x
- cmd_y0  input  8  first corner y
- cmd_x1  input  8  second corner x (rect only)
- cmd_y1  input  8  second corner y (rect only)
- cmd_color  input  3  RGB color
- wr_ready  input  1  framebuffer accepts the presented write
- wr_en  output  1  pixel write valid
- wr_x  output  8  pixel x
- wr_y  output  8  pixel y
- wr_color  output  3  pixel color
- busy  output  1  high whenever state is DRAW

Behaviour:
- Reset state: IDLE, cmd_ready=1, wr_en=0, wr_x=0, wr_y=0, wr_color=0, busy=0.
- States: IDLE and DRAW. cmd_ready = (state==IDLE). busy = (state==DRAW).
- Accept: a command is accepted on a clock edge where cmd_valid and cmd_ready are both high. Inputs are sampled only at accept.
- Normalisation at accept:
  - plot: bounds are x0..x0, y0..y0.
  - rect: x bounds = min(x0,x1)..max(x0,x1); y bounds likewise.
  - clear: bounds are 0..FB_WIDTH-1, 0..FB_HEIGHT-1.
  - Max bounds are clamped to FB_WIDTH-1 / FB_HEIGHT-1.
  - If min x >= FB_WIDTH or min y >= FB_HEIGHT, the command is empty.
- Empty commands and op 11: accepted, no writes, state remains IDLE, cmd_ready stays 1.
- Non-empty command: go to DRAW. The next cycle presents wr_en=1 with the first pixel (xmin, ymin, color); latency is 1 cycle from accept.
- Scan order: x increments fastest. At xmax, x returns to xmin and y increments. Only completed pixels are written.
- Transfer occurs when wr_en && wr_ready. Without a transfer, wr_x, wr_y and wr_color hold stable and wr_en stays 1 (no skips, no duplicates).
- Last pixel (x=xmax, y=ymax) transferred: next cycle wr_en=0, state IDLE, cmd_ready=1.
- Back-to-back commands: a new command may be accepted the cycle cmd_ready returns high. There is therefore ≥1 idle output cycle between commands.
- Throughput: 1 pixel/cycle with wr_ready held high. Full clear = FB_WIDTH*FB_HEIGHT = 19200 write cycles.
- cmd_valid during DRAW is ignored (not accepted); upstream must hold it.
- Reset mid-DRAW: at the reset edge, the command is abandoned, outputs return to reset values, and no further writes occur.
- Counters are 8 bits wide and never wrap past the clamped bounds (max 159/119 with defaults).

Test Plan:
- Plot (5,7) color 3, wr_ready=1 -> one write (5,7,3) exactly 1 cycle after accept; cmd_ready high the following cycle.
- Rect (12,21)-(10,20) color 5 -> 6 writes in order (10,20),(11,20),(12,20),(10,21),(11,21),(12,21); busy high for 6 cycles.
- Rect (158,118)-(200,200) color 1 -> 4 writes (158,118),(159,118),(158,119),(159,119). Plot (170,5) -> zero writes, cmd_ready never drops.
- Clear color 0 -> 19200 consecutive writes, first (0,0), last (159,119), busy falls 1 cycle after the last transfer.
- Rect (0,0)-(1,0) with wr_ready low for 3 cycles on the first pixel -> (0,0) held stable 4 cycles, then (1,0) once; exactly 2 transfers total.
- Reset asserted at the 100th write of a clear -> next cycle wr_en=0, busy=0, cmd_ready=1; a following plot (1,1) executes normally.
